block_dispatch_sched: RTL and testbench
=======================================

Name: block_dispatch_sched

Overview:
Scheduler between the IFE block source and the Nebula core array. It buffers incoming instruction blocks and dispatches parallel blocks round-robin to free cores. Serial blocks run alone on core 0 only after all cores have drained. It tracks per-core outstanding blocks until commit, and replaces the ad-hoc serial/parallel muxing at the core inputs.

Parameters:
NUM_CORES, 2, number of cores scheduled (2..4)
FIFO_DEPTH, 4, block queue entries (power of 2)
ID_W, 8, block id width
WORDS, 4, 32-bit instruction words per block
TIMEOUT_CYC, 1024, watchdog limit; used only with DISPATCH_TIMEOUT_EN

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  block offered
in_ready  out  1  queue not full
in_id  in  ID_W  block id
in_data  in  WORDS*32  block words
in_serial  in  1  1 = block must execute alone
core_busy  in  NUM_CORES  core reports busy
core_commit  in  NUM_CORES  one-cycle pulse: core finished its block
disp_valid  out  NUM_CORES  one-hot dispatch pulse
disp_id  out  ID_W  dispatched block id
disp_data  out  WORDS*32  dispatched block words
outstanding  out  NUM_CORES  core holds an uncommitted block
fifo_count  out  $clog2(FIFO_DEPTH)+1  queued entries
idle  out  1  queue empty, no outstanding, FSM in RUN
err_commit  out  1  sticky: commit pulse from a core not outstanding
timeout_err  out  1  sticky watchdog flag (0 without macro)

Behaviour:
- Reset (rst_n=0 at posedge): queue empty, all outputs 0 except in_ready=1 and idle=1. RR pointer=0. FSM=RUN. Reset mid-operation discards queued and outstanding blocks.
- Queue: push on in_valid&&in_ready. in_ready=(fifo_count<FIFO_DEPTH), no same-cycle pass-through when full. Pointers wrap modulo FIFO_DEPTH. Push and pop in the same cycle leave the count unchanged.
- Core free(i) = !core_busy[i] && !outstanding[i], evaluated on registered state. A commit and a dispatch never target the same core in the same cycle.
- FSM states RUN, DRAIN, SERIAL.
  - RUN, head parallel, any core free: pop. Pick the first free core at or after the RR pointer (wrapping). Set outstanding. RR pointer = chosen+1 mod NUM_CORES.
  - RUN, head serial: no pop. Go to DRAIN.
  - DRAIN: wait until outstanding==0 && core_busy[0]==0. Then pop, dispatch to core 0, set outstanding[0], go to SERIAL.
  - SERIAL: no dispatch. On core_commit[0] go to RUN. The RR pointer is unchanged.
- Dispatch outputs are registered. An entry pushed at edge N is earliest dispatched at edge N+1, with disp_valid high for one cycle after N+1. disp_id and disp_data hold their last value when disp_valid=0.
- At most one dispatch per cycle.
- core_commit[i] clears outstanding[i] at the next edge. If outstanding[i]=0 it is ignored and err_commit is set (cleared only by reset).
- fifo_count and outstanding are registered and reflect the state after the last edge.

Optional Feature:
DISPATCH_TIMEOUT_EN
- Defined: one counter per core, reset on dispatch and counting while outstanding. When it reaches TIMEOUT_CYC, outstanding[i] is force-cleared and timeout_err is set (sticky). If the core is core 0 in SERIAL, the FSM returns to RUN.
- Undefined: no counters, timeout_err tied 0.

Test Plan:
- Reset with in_valid=1 → in_ready=1, idle=1, disp_valid=0, fifo_count=0.
- Push ids 0x10,0x11,0x12 parallel, cores idle → disp_valid 01 (0x10), then 10 (0x11). 0x12 stays queued, fifo_count=1, until core_commit=01, then dispatched to core 0.
- Push 5 blocks with both cores busy, FIFO_DEPTH=4 → in_ready=0 after 4th push, 5th held. fifo_count=4, then wrap-around order preserved on drain.
- Core 1 outstanding, push serial 0x20 → FSM DRAIN, no dispatch. After core_commit=10, 0x20 goes to core 0 (disp_valid=01). A parallel 0x21 behind it waits until core_commit=01.
- core_commit=10 with outstanding=00 → err_commit=1 and stays 1. Queue is unaffected.
- With DISPATCH_TIMEOUT_EN and TIMEOUT_CYC=8: dispatch to core 0, no commit → at cycle 8 outstanding[0]=0 and timeout_err=1.

Source files
------------

// File: rtl/block_dispatch_sched.sv
// Block dispatch scheduler: queues instruction blocks from the IFE source and
// dispatches them to the Nebula cores. Parallel blocks go round-robin to free
// cores; serial blocks wait for all cores to drain, then run alone on core 0.
// Optional per-core watchdog is enabled by defining DISPATCH_TIMEOUT_EN.
module block_dispatch_sched #(
    parameter int unsigned NUM_CORES   = 2,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ID_W        = 8,
    parameter int unsigned WORDS       = 4,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ID_W-1:0]                in_id,
    input  logic [WORDS*32-1:0]            in_data,
    input  logic                           in_serial,
    input  logic [NUM_CORES-1:0]           core_busy,
    input  logic [NUM_CORES-1:0]           core_commit,
    output logic [NUM_CORES-1:0]           disp_valid,
    output logic [ID_W-1:0]                disp_id,
    output logic [WORDS*32-1:0]            disp_data,
    output logic [NUM_CORES-1:0]           outstanding,
    output logic [$clog2(FIFO_DEPTH):0]    fifo_count,
    output logic                           idle,
    output logic                           err_commit,
    output logic                           timeout_err
);

    localparam int unsigned DATA_W = WORDS * 32;
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned RR_W   = $clog2(NUM_CORES);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        SERIAL = 2'd2
    } state_t;

    state_t                 state, state_nxt;
    logic [RR_W-1:0]        rr, rr_nxt, pick;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [ID_W-1:0]        id_mem   [FIFO_DEPTH];
    logic [DATA_W-1:0]      data_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0]  ser_mem;
    logic                   push, pop, found;
    logic [NUM_CORES-1:0]   free, disp_c, to_hit;
    logic [RR_W:0]          sum;

    assign in_ready = (fifo_count < CNT_W'(FIFO_DEPTH));
    assign push     = in_valid && in_ready;
    assign free     = ~core_busy & ~outstanding;
    assign idle     = (fifo_count == '0) && (outstanding == '0) && (state == RUN);

    // Queue storage; contents need no reset since pointers define validity
    always_ff @(posedge clk) begin
        if (push) begin
            id_mem[wr_ptr]   <= in_id;
            data_mem[wr_ptr] <= in_data;
            ser_mem[wr_ptr]  <= in_serial;
        end
    end

    // Round-robin core pick and RUN/DRAIN/SERIAL next-state logic
    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        pop       = 1'b0;
        disp_c    = '0;
        found     = 1'b0;
        pick      = '0;
        sum       = '0;
        for (int k = 0; k < int'(NUM_CORES); k++) begin
            sum = {1'b0, rr} + (RR_W+1)'(k);
            if (sum >= (RR_W+1)'(NUM_CORES)) sum = sum - (RR_W+1)'(NUM_CORES);
            if (!found && free[RR_W'(sum)]) begin
                found = 1'b1;
                pick  = RR_W'(sum);
            end
        end
        case (state)
            RUN: begin
                if (fifo_count != '0) begin
                    if (ser_mem[rd_ptr]) begin
                        state_nxt = DRAIN;
                    end else if (found) begin
                        pop    = 1'b1;
                        disp_c = NUM_CORES'(1) << pick;
                        rr_nxt = (pick == RR_W'(NUM_CORES - 1)) ? '0 : pick + RR_W'(1);
                    end
                end
            end
            DRAIN: begin
                if ((outstanding == '0) && !core_busy[0]) begin
                    pop       = 1'b1;
                    disp_c    = NUM_CORES'(1);
                    state_nxt = SERIAL;
                end
            end
            SERIAL: begin
                if (core_commit[0] || to_hit[0]) state_nxt = RUN;
            end
            default: state_nxt = RUN;
        endcase
    end

    // State, pointers, outstanding tracking and registered dispatch outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RUN;
            rr          <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            outstanding <= '0;
            disp_valid  <= '0;
            disp_id     <= '0;
            disp_data   <= '0;
            err_commit  <= 1'b0;
        end else begin
            state       <= state_nxt;
            rr          <= rr_nxt;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_count  <= fifo_count + CNT_W'(push) - CNT_W'(pop);
            outstanding <= (outstanding & ~core_commit & ~to_hit) | disp_c;
            disp_valid  <= disp_c;
            if (pop) begin
                disp_id   <= id_mem[rd_ptr];
                disp_data <= data_mem[rd_ptr];
            end
            err_commit  <= err_commit | (|(core_commit & ~outstanding));
        end
    end

`ifdef DISPATCH_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TO_W-1:0] to_cnt [NUM_CORES];
    logic            timeout_q;

    // Watchdog fires on the cycle a core has been outstanding TIMEOUT_CYC edges
    always_comb begin
        to_hit = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            to_hit[i] = outstanding[i] && (to_cnt[i] == TO_W'(TIMEOUT_CYC - 1));
        end
    end

    // Per-core watchdog counters, restarted by each dispatch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NUM_CORES); i++) to_cnt[i] <= '0;
            timeout_q <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NUM_CORES); i++) begin
                if (disp_c[i])                        to_cnt[i] <= '0;
                else if (outstanding[i] && !to_hit[i]) to_cnt[i] <= to_cnt[i] + TO_W'(1);
                else                                   to_cnt[i] <= '0;
            end
            timeout_q <= timeout_q | (|to_hit);
        end
    end

    assign timeout_err = timeout_q;
`else
    logic unused_timeout_cfg;

    assign to_hit             = '0;
    assign timeout_err        = 1'b0;
    assign unused_timeout_cfg = ^32'(TIMEOUT_CYC);
`endif

endmodule

// File: tb/tb_block_dispatch_sched.sv
// Directed testbench for block_dispatch_sched (2 cores, 4-entry queue).
module tb_block_dispatch_sched;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_id;
    logic [127:0] in_data;
    logic         in_serial;
    logic [1:0]   core_busy;
    logic [1:0]   core_commit;
    logic [1:0]   disp_valid;
    logic [7:0]   disp_id;
    logic [127:0] disp_data;
    logic [1:0]   outstanding;
    logic [2:0]   fifo_count;
    logic         idle;
    logic         err_commit;
    logic         timeout_err;

    int errors = 0;
    int checks = 0;

    block_dispatch_sched #(
        .NUM_CORES(2), .FIFO_DEPTH(4), .ID_W(8), .WORDS(4), .TIMEOUT_CYC(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id),
        .in_data(in_data), .in_serial(in_serial),
        .core_busy(core_busy), .core_commit(core_commit),
        .disp_valid(disp_valid), .disp_id(disp_id), .disp_data(disp_data),
        .outstanding(outstanding), .fifo_count(fifo_count), .idle(idle),
        .err_commit(err_commit), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [7:0] id;
        logic       ser;
        logic [1:0] busy;
        logic [1:0] cmt;
        logic [1:0] e_dv;
        logic [7:0] e_id;
        logic [2:0] e_cnt;
        logic [1:0] e_out;
        logic       e_rdy;
        logic       e_idle;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [127:0] blk(input logic [7:0] id);
        return {4{id, ~id, 8'hA5, id ^ 8'h3C}};
    endfunction

    function automatic vec_t v(input logic vld, input logic [7:0] id, input logic ser,
                               input logic [1:0] busy, input logic [1:0] cmt,
                               input logic [1:0] e_dv, input logic [7:0] e_id,
                               input logic [2:0] e_cnt, input logic [1:0] e_out,
                               input logic e_rdy, input logic e_idle, input logic e_err);
        vec_t r;
        r.vld = vld; r.id = id; r.ser = ser; r.busy = busy; r.cmt = cmt;
        r.e_dv = e_dv; r.e_id = e_id; r.e_cnt = e_cnt; r.e_out = e_out;
        r.e_rdy = e_rdy; r.e_idle = e_idle; r.e_err = e_err;
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic vld, input logic [7:0] id, input logic ser,
                         input logic [1:0] busy, input logic [1:0] cmt);
        in_valid = vld; in_id = id; in_data = blk(id); in_serial = ser;
        core_busy = busy; core_commit = cmt;
    endtask

    initial begin
        // Reset with a block offered: nothing may be accepted
        rst_n = 1'b0;
        drive(1'b1, 8'h99, 1'b0, 2'b00, 2'b00);
        repeat (2) @(posedge clk);
        #1;
        chk("rst in_ready",   128'(in_ready),   128'(1));
        chk("rst idle",       128'(idle),       128'(1));
        chk("rst disp_valid", 128'(disp_valid), 128'(0));
        chk("rst fifo_count", 128'(fifo_count), 128'(0));
        chk("rst outstanding",128'(outstanding),128'(0));
        chk("rst err_commit", 128'(err_commit), 128'(0));
        chk("rst timeout_err",128'(timeout_err),128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 2'b00);

        //          vld id    ser busy cmt    dv  id    cnt out rdy idl err
        // Round-robin parallel dispatch, third block waits for a commit
        vecs.push_back(v(1, 8'h10, 0, 2'd0, 2'd0,  2'd0, 8'h00, 1, 2'd0, 1, 0, 0));
        vecs.push_back(v(1, 8'h11, 0, 2'd0, 2'd0,  2'd1, 8'h10, 1, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 8'h12, 0, 2'd0, 2'd0,  2'd2, 8'h11, 1, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd0, 8'h00, 1, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd1,  2'd0, 8'h00, 1, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd1, 8'h12, 0, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd3,  2'd0, 8'h00, 0, 2'd0, 1, 1, 0));
        // Fill queue with cores busy, fifth block held, drain in order across the wrap
        vecs.push_back(v(1, 8'h30, 0, 2'd3, 2'd0,  2'd0, 8'h00, 1, 2'd0, 1, 0, 0));
        vecs.push_back(v(1, 8'h31, 0, 2'd3, 2'd0,  2'd0, 8'h00, 2, 2'd0, 1, 0, 0));
        vecs.push_back(v(1, 8'h32, 0, 2'd3, 2'd0,  2'd0, 8'h00, 3, 2'd0, 1, 0, 0));
        vecs.push_back(v(1, 8'h33, 0, 2'd3, 2'd0,  2'd0, 8'h00, 4, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 8'h34, 0, 2'd3, 2'd0,  2'd0, 8'h00, 4, 2'd0, 0, 0, 0));
        vecs.push_back(v(1, 8'h34, 0, 2'd0, 2'd0,  2'd2, 8'h30, 3, 2'd2, 1, 0, 0));
        vecs.push_back(v(1, 8'h34, 0, 2'd0, 2'd0,  2'd1, 8'h31, 3, 2'd3, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd3,  2'd0, 8'h00, 3, 2'd0, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd2, 8'h32, 2, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd2,  2'd1, 8'h33, 1, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd1,  2'd2, 8'h34, 0, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd2,  2'd0, 8'h00, 0, 2'd0, 1, 1, 0));
        // Serial block drains the array, runs alone, parallel block waits behind it
        vecs.push_back(v(1, 8'h1E, 0, 2'd0, 2'd0,  2'd0, 8'h00, 1, 2'd0, 1, 0, 0));
        vecs.push_back(v(1, 8'h1F, 0, 2'd0, 2'd0,  2'd1, 8'h1E, 1, 2'd1, 1, 0, 0));
        vecs.push_back(v(1, 8'h20, 1, 2'd0, 2'd0,  2'd2, 8'h1F, 1, 2'd3, 1, 0, 0));
        vecs.push_back(v(1, 8'h21, 0, 2'd0, 2'd1,  2'd0, 8'h00, 2, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd0, 8'h00, 2, 2'd2, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd2,  2'd0, 8'h00, 2, 2'd0, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd1, 8'h20, 1, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd0, 8'h00, 1, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd1,  2'd0, 8'h00, 1, 2'd0, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd1, 8'h21, 0, 2'd1, 1, 0, 0));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd1,  2'd0, 8'h00, 0, 2'd0, 1, 1, 0));
        // Spurious commit sets sticky error; queue keeps working
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd2,  2'd0, 8'h00, 0, 2'd0, 1, 1, 1));
        vecs.push_back(v(1, 8'h40, 0, 2'd0, 2'd0,  2'd0, 8'h00, 1, 2'd0, 1, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd0,  2'd2, 8'h40, 0, 2'd2, 1, 0, 1));
        vecs.push_back(v(0, 8'h00, 0, 2'd0, 2'd2,  2'd0, 8'h00, 0, 2'd0, 1, 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].vld, vecs[i].id, vecs[i].ser, vecs[i].busy, vecs[i].cmt);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d disp_valid", i), 128'(disp_valid), 128'(vecs[i].e_dv));
            chk($sformatf("v%0d fifo_count", i), 128'(fifo_count), 128'(vecs[i].e_cnt));
            chk($sformatf("v%0d outstanding", i), 128'(outstanding), 128'(vecs[i].e_out));
            chk($sformatf("v%0d in_ready", i), 128'(in_ready), 128'(vecs[i].e_rdy));
            chk($sformatf("v%0d idle", i), 128'(idle), 128'(vecs[i].e_idle));
            chk($sformatf("v%0d err_commit", i), 128'(err_commit), 128'(vecs[i].e_err));
            if (vecs[i].e_dv != 2'd0) begin
                chk($sformatf("v%0d disp_id", i), 128'(disp_id), 128'(vecs[i].e_id));
                chk($sformatf("v%0d disp_data", i), disp_data, blk(vecs[i].e_id));
            end
        end

        // Mid-operation reset discards queue, outstanding, sticky error and RR pointer
        @(negedge clk); drive(1'b1, 8'h50, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("mr push count", 128'(fifo_count), 128'(1));
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("mr disp 50", 128'(disp_valid), 128'(1));
        chk("mr out 50", 128'(outstanding), 128'(1));
        @(negedge clk); rst_n = 1'b0; drive(1'b1, 8'h51, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("mr rst count", 128'(fifo_count), 128'(0));
        chk("mr rst out", 128'(outstanding), 128'(0));
        chk("mr rst disp", 128'(disp_valid), 128'(0));
        chk("mr rst err", 128'(err_commit), 128'(0));
        chk("mr rst idle", 128'(idle), 128'(1));
        @(negedge clk); rst_n = 1'b1; drive(1'b1, 8'h52, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("mr push 52", 128'(fifo_count), 128'(1));
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 2'b00, 2'b00);
        @(posedge clk); #1;
        chk("mr disp 52 core0", 128'(disp_valid), 128'(1));
        chk("mr disp 52 id", 128'(disp_id), 128'(8'h52));

`ifdef DISPATCH_TIMEOUT_EN
        // Core 0 never commits: watchdog clears it after 8 edges
        repeat (7) @(posedge clk);
        #1;
        chk("to before limit out", 128'(outstanding), 128'(1));
        chk("to before limit err", 128'(timeout_err), 128'(0));
        @(posedge clk); #1;
        chk("to at limit out", 128'(outstanding), 128'(0));
        chk("to at limit err", 128'(timeout_err), 128'(1));
`else
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 2'b00, 2'b01);
        @(posedge clk); #1;
        chk("final commit out", 128'(outstanding), 128'(0));
        chk("timeout_err tied", 128'(timeout_err), 128'(0));
        @(negedge clk); drive(1'b0, 8'h00, 1'b0, 2'b00, 2'b00);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
